// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and default widths.
package mips_pkg;

    typedef enum logic [1:0] {
        ADDER_IDLE = 2'd0,
        ADDER_BUSY = 2'd1,
        ADDER_DONE = 2'd2
    } adder_state_t;

    localparam int MIPS_WORD        = 32;
    localparam int MIPS_ADDER_CHUNK = 8;

endpackage

// File: rtl/chunk_adder.sv
// One CHUNK-bit slice of the ripple adder: {cout, sum} = a + b + cin.
// Purely combinational, zero latency, no flow control.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/multicycle_adder.sv
// Add/subtract CHUNK bits per cycle; out_valid NUM_CHUNKS cycles after accept, result held until out_ready.
// Accepts only in IDLE (in_ready). MULTICYCLE_ADDER_SAT_EN enables signed saturation of the result.
module multicycle_adder
    import mips_pkg::*;
#(
    parameter int WIDTH = MIPS_WORD,
    parameter int CHUNK = MIPS_ADDER_CHUNK
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    adder_state_t state_q, state_d;

    logic [NUM_CHUNKS-1:0][CHUNK-1:0] a_q, b_q, res_q, res_next;
    logic [CNT_W-1:0]                 cnt_q;
    logic                             carry_q;
    logic [CHUNK-1:0]                 chunk_sum;
    logic                             chunk_cout;
    logic                             ovf_next;
    logic [WIDTH-1:0]                 res_final;

    assign in_ready  = (state_q == ADDER_IDLE);
    assign out_valid = (state_q == ADDER_DONE);
    assign result    = res_q;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (a_q[cnt_q]),
        .b    (b_q[cnt_q]),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ADDER_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ADDER_IDLE: if (in_valid)            state_d = ADDER_BUSY;
            ADDER_BUSY: if (cnt_q == LAST_CHUNK) state_d = ADDER_DONE;
            ADDER_DONE: if (out_ready)           state_d = ADDER_IDLE;
            default:                             state_d = ADDER_IDLE;
        endcase
    end

    // Overflow and zero look at the result as it will stand after the final chunk lands.
    always_comb begin
        res_next        = res_q;
        res_next[cnt_q] = chunk_sum;
        ovf_next        = (a_q[NUM_CHUNKS-1][CHUNK-1] == b_q[NUM_CHUNKS-1][CHUNK-1]) &&
                          (res_next[NUM_CHUNKS-1][CHUNK-1] != a_q[NUM_CHUNKS-1][CHUNK-1]);
        res_final       = res_next;
`ifdef MULTICYCLE_ADDER_SAT_EN
        if (ovf_next) begin
            res_final = a_q[NUM_CHUNKS-1][CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state_q)
                ADDER_IDLE: begin
                    if (in_valid) begin
                        a_q     <= input1;
                        b_q     <= sub ? ~input2 : input2;
                        carry_q <= sub;
                        cnt_q   <= '0;
                    end
                end
                ADDER_BUSY: begin
                    carry_q <= chunk_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CHUNK) begin
                        res_q     <= res_final;
                        carry_out <= chunk_cout;
                        overflow  <= ovf_next;
                        zero      <= (res_final == '0);
                    end else begin
                        res_q <= res_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_adder.md
Name: multicycle_adder

Overview:
- Parametrised multicycle add/subtract unit for the MIPS datapath. It is the next generation of the single-cycle 32-bit adder.
- It processes operands CHUNK bits per clock, LSB chunk first, using a ripple carry held in a register between chunks.
- It exposes valid/ready handshakes on both sides so the multicycle control FSM can stall on it.
- It produces carry, signed overflow and zero flags for branch and exception logic.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits added per cycle. WIDTH % CHUNK must equal 0; the block issues an elaboration error otherwise.
- NUM_CHUNKS, WIDTH/CHUNK, derived localparam; not overridable.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode are valid this cycle.
- in_ready  out  1  block can accept an operation.
- input1  in  WIDTH  operand A.
- input2  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- carry_out  out  1  carry out of the MSB. For subtract, 1 means no borrow.
- overflow  out  1  signed (two's-complement) overflow.
- zero  out  1  result == 0.

Behaviour:
- Reset: asserting reset_n low immediately forces the following, regardless of state, including mid-operation:
  - state = IDLE
  - result, carry_out, overflow, zero = 0
  - out_valid = 0
  - internal operand registers, chunk counter and carry register = 0
  - Any in-flight operation is discarded. Inputs are ignored while reset_n is low.
- in_ready = (state == IDLE), decoded combinationally from the state register.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on in_valid && in_ready. On that edge the block captures:
    - A = input1
    - B' = sub ? ~input2 : input2
    - carry register = sub
    - chunk counter = 0
  - BUSY: each edge computes {c, r} = A[k] + B'[k] + carry, where k is the chunk counter. It writes r into result[k*CHUNK +: CHUNK], stores c in the carry register and increments the counter.
  - BUSY -> DONE on the edge that processes chunk NUM_CHUNKS-1. On that edge:
    - carry_out = final carry
    - overflow = (A[MSB] == B'[MSB]) && (new result[MSB] != A[MSB])
    - zero = (full new result == 0)
    - out_valid = 1 from the next cycle.
  - DONE: result and flags are held stable while out_valid=1 && out_ready=0.
  - DONE -> IDLE on out_valid && out_ready. out_valid falls on that same edge; result and flags keep their values until the next operation overwrites them.
- Latency: accept edge, then NUM_CHUNKS edges, then out_valid is high. Minimum issue interval is NUM_CHUNKS+2 cycles.
- No overlap: a new operation is accepted only in IDLE. in_valid asserted in BUSY or DONE is ignored, and the producer must hold it.
- Changes to input1, input2 or sub after acceptance have no effect.
- Wrap-around: results are modulo 2^WIDTH, and carry_out reports the lost bit.
- Degenerate case CHUNK == WIDTH: one BUSY cycle.

Optional Feature:
- Macro MULTICYCLE_ADDER_SAT_EN.
- When defined: on signed overflow, result is replaced at the BUSY->DONE edge by 0111..1 (if A[MSB]==0) or 1000..0 (if A[MSB]==1).
  - overflow is still reported.
  - zero is computed on the saturated value.
  - carry_out is unchanged.
- When undefined: wrap-around result only, with no saturation logic in the netlist.

Decomposition:
- Shared package mips_pkg holds:
  - state enum ADDER_IDLE/ADDER_BUSY/ADDER_DONE (2-bit encoding)
  - default width constant MIPS_WORD = 32
  - MIPS_ADDER_CHUNK = 8
- One sub-module is natural: chunk_adder (parametrised CHUNK, combinational, inputs a, b, cin; outputs sum, cout). It is instantiated once and fed by a counter-indexed mux.

Test Plan:
- Reset mid-BUSY: accept 0x0000_0001+0x0000_0001, pull reset_n low after 2 cycles -> all outputs 0 and in_ready=1 immediately. After release, a new op 5+7 -> result=0x0000_000C, carry_out=0, overflow=0, zero=0.
- Latency/handshake: with WIDTH=32, CHUNK=8, accept 0x00FF_00FF+0x0001_0001 -> out_valid rises exactly 4 cycles after the accept edge; result=0x0100_0100.
- Carry ripple across all chunks: 0xFFFF_FFFF+0x0000_0001 -> result=0, carry_out=1, zero=1, overflow=0.
- Subtract and signed overflow:
  - 0x8000_0000-0x0000_0001 -> result=0x7FFF_FFFF, overflow=1, carry_out=1 (no borrow).
  - 3-5 -> result=0xFFFF_FFFE, carry_out=0.
- Back-pressure: hold out_ready=0 for 10 cycles with in_valid=1 and a new operand pair -> result and flags stable, in_ready=0, second op not accepted. On out_ready=1, the block returns to IDLE and the second op is accepted on the next edge.
- With MULTICYCLE_ADDER_SAT_EN: 0x7FFF_FFFF+0x0000_0001 -> result=0x7FFF_FFFF, overflow=1. Without the macro -> result=0x8000_0000.
